// File: rtl/parking_pkg.sv
// Shared types and width helpers for the parking gate controller.
package parking_pkg;

    // Gate controller states; explicit encodings keep the state register stable across tools.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPENING = 3'd2,
        ST_HOLD    = 3'd3,
        ST_CLOSING = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    // Direction of the car currently being served.
    typedef enum logic {
        DIR_ENTRY = 1'b0,
        DIR_EXIT  = 1'b1
    } dir_t;

    // Bits needed to hold every value from 0 up to max_value inclusive.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    localparam int DEFAULT_CAPACITY = 15;
    localparam int DEFAULT_CNT_W    = cnt_width(DEFAULT_CAPACITY);

endpackage

// File: rtl/parking_timer.sv
// Loadable down-counter that rests at zero; done is high while the count is zero.
module parking_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single bidirectional parking gate: exit-priority arbitration, keypad check with
// lockout, timed hold-open, door watchdog and occupancy tracking.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int          CAPACITY     = 15,
    parameter int          PASS_W       = 6,
    parameter int unsigned PASSWORD     = 37,
    parameter int          MAX_TRIES    = 3,
    parameter int          LOCK_CYCLES  = 1000,
    parameter int          DOOR_TIMEOUT = 500,
    parameter int          HOLD_CYCLES  = 100,
    localparam int         CNT_W        = cnt_width(CAPACITY)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              entranceSen,
    input  logic [PASS_W-1:0] entrancePass,
    input  logic              exitSen,
    input  logic              doorMaxOpen,
    input  logic              doorMaxClose,
    output logic              doorOpen,
    output logic              doorClose,
    output logic              okPass,
    output logic              wrongPass,
    output logic [CNT_W-1:0]  carNumber,
    output logic              empty,
    output logic              full,
    output logic              locked,
    output logic              doorFault
);

    localparam int DOOR_MAX = (DOOR_TIMEOUT > HOLD_CYCLES) ? DOOR_TIMEOUT : HOLD_CYCLES;
    localparam int DOOR_W   = cnt_width(DOOR_MAX);
    localparam int LOCK_W   = cnt_width(LOCK_CYCLES);
    localparam int TRY_W    = cnt_width(MAX_TRIES);

    // Door timer is loaded with N-1 so the phase lasts exactly N cycles before done is acted on.
    localparam logic [PASS_W-1:0] PASS_CODE    = PASS_W'(PASSWORD);
    localparam logic [DOOR_W-1:0] TIMEOUT_LOAD = DOOR_W'(DOOR_TIMEOUT - 1);
    localparam logic [DOOR_W-1:0] HOLD_LOAD    = DOOR_W'(HOLD_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD    = LOCK_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(CAPACITY);
    localparam logic [TRY_W-1:0]  TRY_LIMIT    = TRY_W'(MAX_TRIES);

    state_t            state;
    state_t            state_next;
    dir_t              dir;
    logic [TRY_W-1:0]  tries;
    logic              armed;
    logic [CNT_W-1:0]  cars;

    logic              pass_match;
    logic              switch_fault;
    logic              check_ok;
    logic              check_bad;
    logic              last_try;
    logic              door_done;
    logic              door_load;
    logic [DOOR_W-1:0] door_load_value;
    logic              lock_load;
    logic              lock_done;

    assign pass_match   = (entrancePass == PASS_CODE);
    assign switch_fault = doorMaxOpen && doorMaxClose;
    assign check_ok     = (state == ST_CHECK) && pass_match  && !switch_fault;
    assign check_bad    = (state == ST_CHECK) && !pass_match && !switch_fault;
    assign last_try     = ((tries + TRY_W'(1)) == TRY_LIMIT);
    assign lock_load    = check_bad && last_try;

    // Status outputs are decoded from registered state only, never from inputs.
    assign carNumber = cars;
    assign empty     = (cars == '0);
    assign full      = (cars == CNT_FULL);
    assign locked    = !lock_done;
    assign doorOpen  = (state == ST_OPENING);
    assign doorClose = (state == ST_CLOSING);
    assign doorFault = (state == ST_FAULT);

    // Next-state decision; both limit switches at once overrides everything.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (exitSen && !empty) begin
                    state_next = ST_OPENING;
                end else if (entranceSen && armed && !full && !locked) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK:   state_next = pass_match ? ST_OPENING : ST_IDLE;
            ST_OPENING: begin
                if (doorMaxOpen) begin
                    state_next = ST_HOLD;
                end else if (door_done) begin
                    state_next = ST_FAULT;
                end
            end
            ST_HOLD: begin
                if (door_done) begin
                    state_next = ST_CLOSING;
                end
            end
            ST_CLOSING: begin
                if (doorMaxClose) begin
                    state_next = ST_IDLE;
                end else if (door_done) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT:   state_next = ST_FAULT;
            default:    state_next = ST_FAULT;
        endcase
        if (switch_fault) begin
            state_next = ST_FAULT;
        end
    end

    // Reload the door timer whenever a timed door phase is entered.
    always_comb begin
        door_load       = 1'b0;
        door_load_value = TIMEOUT_LOAD;
        if (state_next != state) begin
            case (state_next)
                ST_OPENING, ST_CLOSING: door_load = 1'b1;
                ST_HOLD: begin
                    door_load       = 1'b1;
                    door_load_value = HOLD_LOAD;
                end
                default: door_load = 1'b0;
            endcase
        end
    end

    // State register, service direction and single-cycle code pulses.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= ST_IDLE;
            dir       <= DIR_ENTRY;
            okPass    <= 1'b0;
            wrongPass <= 1'b0;
        end else begin
            state     <= state_next;
            okPass    <= check_ok;
            wrongPass <= check_bad;
            if (state == ST_IDLE && state_next == ST_OPENING) begin
                dir <= DIR_EXIT;
            end else if (state == ST_IDLE && state_next == ST_CHECK) begin
                dir <= DIR_ENTRY;
            end
        end
    end

    // Wrong-code counter and one-code-per-car arming.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tries <= '0;
            armed <= 1'b1;
        end else begin
            if (check_ok) begin
                tries <= '0;
            end else if (check_bad) begin
                tries <= last_try ? '0 : tries + TRY_W'(1);
            end
            if (state == ST_CHECK) begin
                armed <= 1'b0;
            end else if (!entranceSen) begin
                armed <= 1'b1;
            end
        end
    end

    // Occupancy changes only when a service completes at the closed limit switch.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cars <= '0;
        end else if (state == ST_CLOSING && doorMaxClose && !switch_fault) begin
            cars <= (dir == DIR_EXIT) ? cars - CNT_W'(1) : cars + CNT_W'(1);
        end
    end

    parking_timer #(.WIDTH(DOOR_W)) u_door_timer (
        .clk        (clk),
        .rstN       (rstN),
        .load       (door_load),
        .load_value (door_load_value),
        .done       (door_done)
    );

    parking_timer #(.WIDTH(LOCK_W)) u_lock_timer (
        .clk        (clk),
        .rstN       (rstN),
        .load       (lock_load),
        .load_value (LOCK_LOAD),
        .done       (lock_done)
    );

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomized self-checking bench for parking_gate_ctrl with a transaction-level occupancy/lock model.
module tb_parking_gate_ctrl;

    localparam int CAPACITY     = 15;
    localparam int PASS_W       = 6;
    localparam int PASSWORD     = 37;
    localparam int MAX_TRIES    = 3;
    localparam int LOCK_CYCLES  = 1000;
    localparam int DOOR_TIMEOUT = 500;
    localparam int HOLD_CYCLES  = 100;
    localparam int CNT_W        = $clog2(CAPACITY + 1);

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              entranceSen = 1'b0;
    logic [PASS_W-1:0] entrancePass = '0;
    logic              exitSen = 1'b0;
    logic              doorMaxOpen = 1'b0;
    logic              doorMaxClose = 1'b1;
    logic              doorOpen, doorClose, okPass, wrongPass;
    logic [CNT_W-1:0]  carNumber;
    logic              empty, full, locked, doorFault;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: occupancy, consecutive wrong codes, cycle at which lock ends.
    int m_cars     = 0;
    int m_tries    = 0;
    int m_lock_end = 0;

    parking_gate_ctrl #(
        .CAPACITY(CAPACITY), .PASS_W(PASS_W), .PASSWORD(PASSWORD), .MAX_TRIES(MAX_TRIES),
        .LOCK_CYCLES(LOCK_CYCLES), .DOOR_TIMEOUT(DOOR_TIMEOUT), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk(clk), .rstN(rstN), .entranceSen(entranceSen), .entrancePass(entrancePass),
        .exitSen(exitSen), .doorMaxOpen(doorMaxOpen), .doorMaxClose(doorMaxClose),
        .doorOpen(doorOpen), .doorClose(doorClose), .okPass(okPass), .wrongPass(wrongPass),
        .carNumber(carNumber), .empty(empty), .full(full), .locked(locked), .doorFault(doorFault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic bit m_locked();
        return cyc < m_lock_end;
    endfunction

    task automatic chk_count(input string tag);
        chk({tag, "_count"}, carNumber, m_cars);
        chk({tag, "_empty"}, empty, m_cars == 0);
        chk({tag, "_full"},  full,  m_cars == CAPACITY);
    endtask

    task automatic do_reset();
        entranceSen  = 1'b0;
        exitSen      = 1'b0;
        doorMaxOpen  = 1'b0;
        doorMaxClose = 1'b1;
        rstN         = 1'b0;
        m_cars       = 0;
        m_tries      = 0;
        m_lock_end   = 0;
        tick();
        tick();
        rstN = 1'b1;
        tick();
    endtask

    // Called with the door opening; drives the limit switches like a real door and checks hold length.
    task automatic run_door(input bit is_exit, input string tag);
        int  d;
        int  n;
        bit  reopened;
        doorMaxClose = 1'b0;
        d = $urandom_range(1, 20);
        repeat (d) tick();
        chk({tag, "_opening"}, doorOpen, 1);
        doorMaxOpen = 1'b1;
        tick();
        chk({tag, "_hold_motors"}, {doorOpen, doorClose}, 0);
        n = 1;
        reopened = 1'b0;
        while (!doorClose && n <= HOLD_CYCLES + 5) begin
            tick();
            n++;
            reopened |= doorOpen;
        end
        chk({tag, "_hold_len"}, n - 1, HOLD_CYCLES);
        chk({tag, "_hold_no_open"}, reopened, 0);
        doorMaxOpen = 1'b0;
        d = $urandom_range(1, 20);
        repeat (d) tick();
        chk({tag, "_closing"}, doorClose, 1);
        chk({tag, "_count_before_close"}, carNumber, m_cars);
        doorMaxClose = 1'b1;
        tick();
        m_cars += is_exit ? -1 : 1;
        chk({tag, "_closed_motors"}, {doorOpen, doorClose}, 0);
        chk_count(tag);
    endtask

    task automatic do_entry(input logic [PASS_W-1:0] code, input string tag);
        bit eligible;
        bit good;
        if (cyc >= m_lock_end - 3 && cyc <= m_lock_end + 3) repeat (7) tick();
        chk({tag, "_locked_state"}, locked, m_locked());
        eligible     = (m_cars < CAPACITY) && !m_locked();
        good         = eligible && (code == PASSWORD);
        entranceSen  = 1'b1;
        entrancePass = code;
        tick();
        chk({tag, "_check_quiet"}, {okPass, wrongPass, doorOpen}, 0);
        tick();
        chk({tag, "_okPass"},    okPass,    good);
        chk({tag, "_wrongPass"}, wrongPass, eligible && !good);
        chk({tag, "_doorOpen"},  doorOpen,  good);
        if (good) begin
            m_tries = 0;
        end else if (eligible) begin
            m_tries++;
            if (m_tries == MAX_TRIES) begin
                m_tries    = 0;
                m_lock_end = cyc + LOCK_CYCLES;
            end
        end
        if (good) begin
            tick();
            chk({tag, "_pulse_width"}, {okPass, wrongPass}, 0);
            entranceSen = 1'b0;
            run_door(1'b0, tag);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tick();
                chk({tag, "_no_retry"}, {okPass, wrongPass, doorOpen}, 0);
            end
            entranceSen = 1'b0;
            tick();
            chk_count(tag);
        end
    endtask

    task automatic do_exit(input string tag);
        bit eligible;
        eligible = (m_cars > 0);
        exitSen = 1'b1;
        tick();
        exitSen = 1'b0;
        chk({tag, "_doorOpen"}, doorOpen, eligible);
        if (eligible) begin
            run_door(1'b1, tag);
        end else begin
            tick();
            chk({tag, "_idle_motors"}, {doorOpen, doorClose}, 0);
            chk_count(tag);
        end
    endtask

    task automatic wait_unlock();
        while (cyc < m_lock_end + 3) tick();
        chk("unlock", locked, 0);
    endtask

    function automatic logic [PASS_W-1:0] wrong_code();
        logic [PASS_W-1:0] c;
        c = PASS_W'($urandom_range(0, 63));
        if (c == PASS_W'(PASSWORD)) c = c + 1'b1;
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_motors", {doorOpen, doorClose}, 0);
        chk("rst_pulses", {okPass, wrongPass}, 0);
        chk("rst_status", {locked, doorFault}, 0);
        chk_count("rst");

        // Reset while holding the door open abandons the service
        entranceSen  = 1'b1;
        entrancePass = PASS_W'(PASSWORD);
        tick();
        tick();
        chk("hold_rst_ok", okPass, 1);
        entranceSen  = 1'b0;
        doorMaxClose = 1'b0;
        repeat (3) tick();
        doorMaxOpen = 1'b1;
        repeat (10) tick();
        chk("hold_rst_in_hold", {doorOpen, doorClose}, 0);
        #2 rstN = 1'b0;
        #1;
        chk("hold_rst_outputs", {doorOpen, doorClose, okPass, wrongPass, locked, doorFault}, 0);
        chk("hold_rst_count", carNumber, 0);
        chk("hold_rst_empty", empty, 1);
        do_reset();
        chk_count("after_hold_rst");

        // Exit while empty is ignored; then a correct entry
        do_exit("exit_empty");
        do_entry(PASS_W'(PASSWORD), "entry_first");

        // Three wrong codes lock the entrance; correct code ignored; exit still served
        for (int i = 0; i < MAX_TRIES; i++) do_entry(wrong_code(), "wrong_code");
        chk("lock_set", locked, 1);
        do_entry(PASS_W'(PASSWORD), "code_while_locked");
        do_exit("exit_while_locked");
        chk("lock_still", locked, 1);
        wait_unlock();

        // Randomized mix of services
        for (int i = 0; i < 16; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) do_entry((r == 0) ? wrong_code() : PASS_W'(PASSWORD), "rand_entry");
            else       do_exit("rand_exit");
        end

        // Both sensors with five cars: exit first, then the waiting entry
        wait_unlock();
        while (m_cars < 5) do_entry(PASS_W'(PASSWORD), "to_five");
        while (m_cars > 5) do_exit("to_five");
        entranceSen  = 1'b1;
        entrancePass = PASS_W'(PASSWORD);
        exitSen      = 1'b1;
        tick();
        exitSen = 1'b0;
        chk("both_exit_first", doorOpen, 1);
        chk("both_no_code", {okPass, wrongPass}, 0);
        run_door(1'b1, "both_exit");
        do_entry(PASS_W'(PASSWORD), "both_entry");

        // Fill to capacity, further entry ignored
        while (m_cars < CAPACITY) do_entry(PASS_W'(PASSWORD), "fill");
        chk("full_flag", full, 1);
        do_entry(PASS_W'(PASSWORD), "entry_when_full");

        // Door never reaches the open limit: watchdog fault
        begin
            int n;
            exitSen = 1'b1;
            tick();
            exitSen = 1'b0;
            chk("wd_open", doorOpen, 1);
            doorMaxClose = 1'b0;
            repeat (DOOR_TIMEOUT - 11) tick();
            chk("wd_no_fault_yet", {doorFault, doorOpen}, 2'b01);
            n = 0;
            while (!doorFault && n < 30) begin
                tick();
                n++;
            end
            chk("wd_fault", doorFault, 1);
            chk("wd_motors", {doorOpen, doorClose}, 0);
            exitSen = 1'b1;
            doorMaxClose = 1'b1;
            repeat (5) tick();
            exitSen = 1'b0;
            chk("wd_frozen_count", carNumber, m_cars);
            chk("wd_sticky", doorFault, 1);
            chk("wd_motors_off", {doorOpen, doorClose}, 0);
        end
        do_reset();
        chk("fault_cleared", doorFault, 0);
        chk_count("after_wd_rst");

        // Both limit switches in idle
        doorMaxOpen = 1'b1;
        tick();
        chk("switch_fault", doorFault, 1);
        chk("switch_fault_motors", {doorOpen, doorClose}, 0);
        do_reset();
        chk("switch_fault_cleared", doorFault, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
